ss: RTL and testbench
=====================

// Module: ss
//
// PURPOSE
// - BCD/hex-to-seven-segment decoder with registered outputs.
// - Converts a 4-bit code into the seven segment drives a..g of one digit.
// - Sits between the numeric datapath and a single display digit, one instance per digit.
// - Default mode is BCD: 0-9 are shown and 10-15 are blanked.
//
// PARAMETERS
// - HEX_EN      default 0 : 1 = codes 10-15 show A,b,C,d,E,F; 0 = codes 10-15 blank all segments
// - ACTIVE_LOW  default 0 : 1 = invert all segment outputs (common-anode drive); 0 = 1 lights a segment
//
// PORTS
// - clk   in   1  system clock, rising-edge active
// - rst   in   1  asynchronous, active-high reset
// - in    in   4  code to display, unsigned 0-15
// - a     out  1  segment a (top)
// - b     out  1  segment b (top right)
// - c     out  1  segment c (bottom right)
// - d     out  1  segment d (bottom)
// - e     out  1  segment e (bottom left)
// - f     out  1  segment f (top left)
// - g     out  1  segment g (middle)
//
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high.
// - Reset: all segments are unlit, i.e. a..g = 0 when ACTIVE_LOW=0 and a..g = 1 when ACTIVE_LOW=1.
//   Reset takes effect immediately on rst assertion, not on a clock edge.
// - Latency: on each rising clk edge with rst low, a..g take the decode of the `in` value sampled at that edge.
//   The outputs then hold until the next edge, so latency is exactly 1 cycle and there is no handshake.
// - Decode table, shown as {a,b,c,d,e,f,g} before any ACTIVE_LOW inversion:
//   - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
//   - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
//   - with HEX_EN=1: 10=1110111 (A), 11=0011111 (b), 12=1001110 (C), 13=0111101 (d), 14=1001111 (E), 15=1000111 (F)
//   - with HEX_EN=0: codes 10-15 give 0000000 (blank)
// - X/Z on `in`: the decode default branch blanks the digit.
// - ACTIVE_LOW is a pure output inversion applied after decode. It also applies to the reset and blank patterns.
// - Reset mid-operation: outputs blank at once. The first post-reset edge loads the decode of the current `in`.
// - `in` changing every cycle: each edge captures its own code independently. No filtering or holding.
//
// STRUCTURE
// - Shared package ss_pkg holds:
//   - localparam SEG_W = 7
//   - a typedef seg_t = logic [6:0], ordered {a,b,c,d,e,f,g}
//   - the 16 segment pattern constants SEG_0..SEG_F and SEG_BLANK
// - One combinational sub-module, ss_decode (in[3:0] -> seg_t, parameter HEX_EN).
//   Wrap it with a 7-bit output register plus the ACTIVE_LOW inversion.
//
// TESTING
// 1. Assert rst with in=4'd8 and no clock edge -> a..g=0000000 immediately.
//    Release rst, one edge later -> 1111111.
// 2. Drive in=0..9, one per cycle, with HEX_EN=0 -> each output appears 1 cycle later and matches the table.
//    Example: in=2 -> 1101101; in=9 -> 1111011.
// 3. HEX_EN=0, in=4'd10..4'd15 -> 0000000. Then HEX_EN=1, in=4'hA -> 1110111 and in=4'hF -> 1000111.
// 4. ACTIVE_LOW=1, in=1 -> a..g=1001111; during reset -> 1111111.
// 5. Assert rst asynchronously between edges while in=7 is displayed -> outputs blank before the next edge.
//    Release rst -> 1110000 after the next edge.
// 6. Change `in` every cycle (3,4,5) -> outputs 1111001, 0110011, 1011011 on successive edges with no skipped codes.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared types and segment patterns for the seven-segment digit driver.
// Patterns are ordered {a,b,c,d,e,f,g}, with a 1 meaning the segment is lit.
package ss_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/ss_decode.sv
// Combinational 4-bit code to active-high segment pattern decoder.
// Codes 10-15 show hex letters only when HEX_EN is set; otherwise they blank.
module ss_decode
  import ss_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] in,
  output seg_t       seg_c
);

  // Unknown codes (including X/Z) fall through to the blank default.
  always_comb begin
    seg_c = SEG_BLANK;
    case (in)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = HEX_EN ? SEG_A : SEG_BLANK;
      4'hB: seg_c = HEX_EN ? SEG_B : SEG_BLANK;
      4'hC: seg_c = HEX_EN ? SEG_C : SEG_BLANK;
      4'hD: seg_c = HEX_EN ? SEG_D : SEG_BLANK;
      4'hE: seg_c = HEX_EN ? SEG_E : SEG_BLANK;
      4'hF: seg_c = HEX_EN ? SEG_F : SEG_BLANK;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ss.sv
// Single-digit seven-segment driver: decode, optional polarity inversion, one register stage.
// Inversion sits before the register so the pins come straight from flops.
module ss
  import ss_pkg::*;
#(
  parameter bit HEX_EN     = 1'b0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam seg_t SEG_POL = {SEG_W{ACTIVE_LOW}};

  seg_t dec_c;
  seg_t seg_q;

  ss_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .in    (in),
    .seg_c (dec_c)
  );

  // Reset shows the blank pattern in the selected drive polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK ^ SEG_POL;
    end else begin
      seg_q <= dec_c ^ SEG_POL;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_ss.sv
// Self-checking bench for ss: four instances cover every HEX_EN/ACTIVE_LOW combination.
// Instance k uses HEX_EN = k%2 and ACTIVE_LOW = k/2.
module tb_ss;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [6:0] s0, s1, s2, s3;
  logic [6:0] seg_obs [4];

  int tests = 0;
  int fails = 0;

  // Glyph table written straight from the digit shapes, {a,b,c,d,e,f,g}.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  ss #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) u_bcd (
    .clk(clk), .rst(rst), .in(in),
    .a(s0[6]), .b(s0[5]), .c(s0[4]), .d(s0[3]), .e(s0[2]), .f(s0[1]), .g(s0[0]));
  ss #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) u_hex (
    .clk(clk), .rst(rst), .in(in),
    .a(s1[6]), .b(s1[5]), .c(s1[4]), .d(s1[3]), .e(s1[2]), .f(s1[1]), .g(s1[0]));
  ss #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b1)) u_bcd_al (
    .clk(clk), .rst(rst), .in(in),
    .a(s2[6]), .b(s2[5]), .c(s2[4]), .d(s2[3]), .e(s2[2]), .f(s2[1]), .g(s2[0]));
  ss #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b1)) u_hex_al (
    .clk(clk), .rst(rst), .in(in),
    .a(s3[6]), .b(s3[5]), .c(s3[4]), .d(s3[3]), .e(s3[2]), .f(s3[1]), .g(s3[0]));

  assign seg_obs[0] = s0;
  assign seg_obs[1] = s1;
  assign seg_obs[2] = s2;
  assign seg_obs[3] = s3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what instance k should show for a code, or for a blanked/reset digit.
  function automatic logic [6:0] ref_seg(input logic [3:0] code, input int k, input bit blank);
    logic [6:0] lit;
    bit hex_en;
    bit active_low;
    hex_en     = (k % 2) == 1;
    active_low = (k / 2) == 1;
    if (blank) lit = 7'b0000000;
    else if (code <= 4'd9 || hex_en) lit = GLYPH[code];
    else lit = 7'b0000000;
    return active_low ? ~lit : lit;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in  = 4'd8;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (seg_obs[k] !== ref_seg(4'd0, k, 1'b1)) begin
        fails++;
        $display("FAIL reset_blank inst%0d got=%b exp=%b", k, seg_obs[k], ref_seg(4'd0, k, 1'b1));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (seg_obs[k] !== ref_seg(4'd8, k, 1'b0)) begin
        fails++;
        $display("FAIL reset_release inst%0d got=%b exp=%b", k, seg_obs[k], ref_seg(4'd8, k, 1'b0));
      end
    end
  endtask

  task automatic test_digits();
    for (int v = 0; v < 16; v++) begin
      in = 4'(v);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (seg_obs[k] !== ref_seg(4'(v), k, 1'b0)) begin
          fails++;
          $display("FAIL digit_%0d inst%0d got=%b exp=%b", v, k, seg_obs[k], ref_seg(4'(v), k, 1'b0));
        end
      end
    end
  endtask

  task automatic test_active_low();
    in = 4'd1;
    @(negedge clk);
    tests++;
    if (s2 !== 7'b1001111) begin
      fails++;
      $display("FAIL active_low_one got=%b exp=%b", s2, 7'b1001111);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (s2 !== 7'b1111111) begin
      fails++;
      $display("FAIL active_low_reset got=%b exp=%b", s2, 7'b1111111);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    in = 4'd7;
    @(negedge clk);
    tests++;
    if (s0 !== 7'b1110000) begin
      fails++;
      $display("FAIL seven_shown got=%b exp=%b", s0, 7'b1110000);
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (seg_obs[k] !== ref_seg(4'd7, k, 1'b1)) begin
        fails++;
        $display("FAIL midcycle_reset inst%0d got=%b exp=%b", k, seg_obs[k], ref_seg(4'd7, k, 1'b1));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (seg_obs[k] !== ref_seg(4'd7, k, 1'b0)) begin
        fails++;
        $display("FAIL post_reset_load inst%0d got=%b exp=%b", k, seg_obs[k], ref_seg(4'd7, k, 1'b0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] want [3] = '{7'b1111001, 7'b0110011, 7'b1011011};
    for (int i = 0; i < 3; i++) begin
      in = 4'(3 + i);
      @(negedge clk);
      tests++;
      if (s0 !== want[i]) begin
        fails++;
        $display("FAIL back_to_back_%0d got=%b exp=%b", i, s0, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] code;
    for (int i = 0; i < 200; i++) begin
      code = 4'($urandom_range(0, 15));
      in   = code;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (seg_obs[k] !== ref_seg(code, k, 1'b0)) begin
          fails++;
          $display("FAIL random_%0d inst%0d code=%0d got=%b exp=%b", i, k, code, seg_obs[k],
                   ref_seg(code, k, 1'b0));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in  = 4'd0;
    test_reset();
    test_digits();
    test_active_low();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
